// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared types and constants for the Ethernet receive parser.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        HEADER   = 3'd2,
        PAYLOAD  = 3'd3,
        FLUSH    = 3'd4,
        DROP     = 3'd5
    } eth_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam int          HDR_LEN       = 14;
    localparam int          FCS_LEN       = 4;
    localparam int          BUF_DEPTH     = FCS_LEN + 1;

endpackage
`default_nettype wire

// File: rtl/eth_crc32_byte.sv
`default_nettype none
// ============================================================================
// Module      : eth_crc32_byte
// Description : Combinational one-byte step of the reflected Ethernet CRC-32.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ d[i]}});
        end
        return c;
    endfunction

    assign crc_out = crc_step(crc_in, data);

endmodule
`default_nettype wire

// File: rtl/eth_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_parser
// Description : Ethernet receive parser: preamble/SFD detect, header capture,
//               FCS-stripped payload stream and per-frame status.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_parser
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1500,
    parameter int MIN_PAYLOAD = 46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        frame_done,
    output logic        err_crc,
    output logic        err_short,
    output logic        err_long,
    output logic        err_line
);

    localparam logic [16:0] c_long_lim  = 17'(MAX_PAYLOAD + FCS_LEN);
    localparam logic [16:0] c_short_lim = 17'(MIN_PAYLOAD + FCS_LEN);
    localparam logic [3:0]  c_hdr_last  = 4'(HDR_LEN - 1);
    localparam logic [2:0]  c_buf_full  = 3'(BUF_DEPTH);

    eth_state_t  r_state, w_state_nxt;
    logic [2:0]  r_pre_cnt;
    logic [3:0]  r_hdr_cnt;
    logic [15:0] r_post_cnt, w_post_inc;
    logic [2:0]  r_buf_cnt;
    logic [39:0] r_buf;
    logic [31:0] r_crc, w_crc_nxt;
    logic        r_in_frame, r_seen_idle, r_long, r_line;
    logic        w_sfd, w_hdr_byte, w_pay_byte, w_overflow, w_end_frame;
    logic        w_crc_en, w_emit, w_short;

    eth_crc32_byte u_crc (
        .crc_in  (r_crc),
        .data    (rx_data),
        .crc_out (w_crc_nxt)
    );

    assign w_post_inc = (r_post_cnt == 16'hFFFF) ? r_post_cnt : r_post_cnt + 16'd1;
    assign w_short    = (r_post_cnt < 16'(BUF_DEPTH)) || ({1'b0, r_post_cnt} < c_short_lim);
    assign w_emit     = (w_pay_byte || w_overflow) && (r_buf_cnt == c_buf_full);
    assign w_crc_en   = rx_valid && r_in_frame &&
                        (r_state == HEADER || r_state == PAYLOAD || r_state == DROP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sfd       = 1'b0;
        w_hdr_byte  = 1'b0;
        w_pay_byte  = 1'b0;
        w_overflow  = 1'b0;
        w_end_frame = 1'b0;
        case (r_state)
            // FLUSH behaves like IDLE so a frame may start right after the gap cycle
            IDLE, FLUSH: begin
                if (rx_valid) begin
                    if (r_seen_idle && rx_data == PREAMBLE_BYTE) w_state_nxt = PREAMBLE;
                    else                                         w_state_nxt = DROP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PREAMBLE: begin
                if (!rx_valid) begin
                    w_state_nxt = IDLE;
                end else if (rx_data == SFD_BYTE) begin
                    w_state_nxt = HEADER;
                    w_sfd       = 1'b1;
                end else if (rx_data != PREAMBLE_BYTE || r_pre_cnt == 3'd7) begin
                    w_state_nxt = DROP;
                end
            end
            HEADER: begin
                if (!rx_valid) begin
                    w_state_nxt = FLUSH;
                    w_end_frame = 1'b1;
                end else begin
                    w_hdr_byte = 1'b1;
                    if (r_hdr_cnt == c_hdr_last) w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!rx_valid) begin
                    w_state_nxt = FLUSH;
                    w_end_frame = 1'b1;
                end else if ({1'b0, w_post_inc} > c_long_lim) begin
                    w_state_nxt = DROP;
                    w_overflow  = 1'b1;
                end else begin
                    w_pay_byte = 1'b1;
                end
            end
            DROP: begin
                if (!rx_valid) begin
                    w_state_nxt = IDLE;
                    w_end_frame = r_in_frame;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt   <= '0;
            r_hdr_cnt   <= '0;
            r_post_cnt  <= '0;
            r_buf_cnt   <= '0;
            r_buf       <= '0;
            r_crc       <= CRC_INIT;
            r_in_frame  <= 1'b0;
            r_seen_idle <= 1'b0;
            r_long      <= 1'b0;
            r_line      <= 1'b0;
            dst_mac     <= '0;
            src_mac     <= '0;
            ethertype   <= '0;
            hdr_valid   <= 1'b0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            frame_done  <= 1'b0;
            err_crc     <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_line    <= 1'b0;
        end else begin
            hdr_valid  <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;

            // A frame already in flight at reset release is never trusted
            if (!rx_valid) r_seen_idle <= 1'b1;

            if (w_state_nxt == PREAMBLE)
                r_pre_cnt <= (r_state == PREAMBLE) ? r_pre_cnt + 3'd1 : 3'd1;

            if (w_sfd) begin
                r_crc      <= CRC_INIT;
                r_hdr_cnt  <= '0;
                r_post_cnt <= '0;
                r_buf_cnt  <= '0;
                r_in_frame <= 1'b1;
                r_long     <= 1'b0;
                r_line     <= 1'b0;
            end else if (w_crc_en) begin
                r_crc <= w_crc_nxt;
                if (rx_err) r_line <= 1'b1;
            end

            if (w_hdr_byte) begin
                r_hdr_cnt <= r_hdr_cnt + 4'd1;
                if (r_hdr_cnt < 4'd6)       dst_mac   <= {dst_mac[39:0], rx_data};
                else if (r_hdr_cnt < 4'd12) src_mac   <= {src_mac[39:0], rx_data};
                else                        ethertype <= {ethertype[7:0], rx_data};
                if (r_hdr_cnt == c_hdr_last) hdr_valid <= 1'b1;
            end

            if (w_pay_byte || w_overflow) begin
                r_post_cnt <= w_post_inc;
                r_buf      <= {r_buf[31:0], rx_data};
                if (r_buf_cnt != c_buf_full) r_buf_cnt <= r_buf_cnt + 3'd1;
            end

            if (w_emit) begin
                m_valid <= 1'b1;
                m_data  <= r_buf[39:32];
            end

            if (w_overflow) r_long <= 1'b1;

            if (w_end_frame) begin
                frame_done <= 1'b1;
                r_in_frame <= 1'b0;
                err_crc    <= (r_crc != CRC_RESIDUE);
                err_short  <= w_short;
                err_long   <= r_long;
                err_line   <= r_line;
                // Only a full delay buffer holds a real last payload byte ahead of the FCS
                if (r_state == PAYLOAD && r_buf_cnt == c_buf_full) begin
                    m_valid <= 1'b1;
                    m_last  <= 1'b1;
                    m_data  <= r_buf[39:32];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_parser
// Description : Directed, table-driven self-checking bench for eth_rx_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype;
    logic        hdr_valid, m_valid, m_last, frame_done;
    logic [7:0]  m_data;
    logic        err_crc, err_short, err_long, err_line;

    eth_rx_parser #(.MAX_PAYLOAD(1500), .MIN_PAYLOAD(46)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .ethertype  (ethertype),
        .hdr_valid  (hdr_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .frame_done (frame_done),
        .err_crc    (err_crc),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_line   (err_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        int plen;
        bit pat;
        bit bad;
        int err_at;
        int gap;
        int e_out;
        bit e_last;
        bit e_short;
        bit e_crc;
        bit e_long;
        bit e_line;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    logic [7:0]   tx_q [$];
    logic [7:0]   exp_pl [$];
    logic [111:0] hdr_bits = {48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800};
    logic [31:0]  dead_w   = 32'hDEADBEEF;

    int n_checks = 0;
    int n_fail   = 0;

    int out_cnt = 0, last_cnt = 0, last_at = 0, hdr_seen = 0, data_bad = 0, done_cnt = 0;
    int s_out, s_last, s_last_at, s_hdr, s_bad;
    logic [3:0] s_flags;

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++)
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return c;
    endfunction

    function automatic logic [31:0] crc_range(input int first, input int last);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = first; i <= last; i++) c = crc_upd(c, tx_q[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input int plen, input bit pat, input bit bad);
        logic [31:0] c;
        logic [7:0]  b;
        tx_q.delete();
        exp_pl.delete();
        repeat (7) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        for (int i = 0; i < 14; i++) tx_q.push_back(hdr_bits[111-8*i -: 8]);
        for (int i = 0; i < plen; i++) begin
            if (pat)        b = 8'(i * 13 + 7);
            else if (i < 4) b = dead_w[31-8*i -: 8];
            else            b = 8'h00;
            tx_q.push_back(b);
            exp_pl.push_back(b);
        end
        c = ~crc_range(8, tx_q.size() - 1);
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[23:16]);
        tx_q.push_back(c[31:24]);
        if (bad) begin
            tx_q[8+14+5]  = tx_q[8+14+5] ^ 8'h01;
            exp_pl[5]     = exp_pl[5] ^ 8'h01;
        end
    endtask

    // Drives on the falling edge; the caller is always positioned at a falling edge
    task automatic send(input int n, input int err_idx, input int gap);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
            rx_err   = (i == err_idx);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input string tag);
        int d0;
        d0 = done_cnt;
        build(v.plen, v.pat, v.bad);
        send(tx_q.size(), (v.err_at < 0) ? -1 : 22 + v.err_at, v.gap);
        check({tag, " done"},    done_cnt - d0, 1);
        check({tag, " hdr"},     s_hdr, 1);
        check({tag, " out"},     s_out, v.e_out);
        check({tag, " last"},    s_last, v.e_last);
        check({tag, " last_at"}, s_last_at, v.e_last ? v.e_out : 0);
        check({tag, " data"},    s_bad, 0);
        check({tag, " flags"},   s_flags, {v.e_short, v.e_crc, v.e_long, v.e_line});
        check({tag, " fields"},  {dst_mac, src_mac, ethertype}, hdr_bits);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            out_cnt = 0; last_cnt = 0; last_at = 0; hdr_seen = 0; data_bad = 0;
        end else begin
            if (hdr_valid) hdr_seen++;
            if (m_valid) begin
                if (out_cnt < exp_pl.size() && m_data !== exp_pl[out_cnt]) data_bad++;
                out_cnt++;
                if (m_last) begin
                    last_cnt++;
                    last_at = out_cnt;
                end
            end else if (m_last) begin
                last_cnt++;
            end
            if (frame_done) begin
                s_out     = out_cnt;
                s_last    = last_cnt;
                s_last_at = last_at;
                s_hdr     = hdr_seen;
                s_bad     = data_bad;
                s_flags   = {err_short, err_crc, err_long, err_line};
                done_cnt++;
                out_cnt = 0; last_cnt = 0; last_at = 0; hdr_seen = 0; data_bad = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [31:0] c;

        vecs[0] = '{46,   0, 0, -1, 3, 46,   1, 0, 0, 0, 0};
        vecs[1] = '{46,   0, 1, -1, 1, 46,   1, 0, 1, 0, 0};
        vecs[2] = '{10,   1, 0, -1, 1, 10,   1, 1, 0, 0, 0};
        vecs[3] = '{1501, 1, 0, -1, 2, 1500, 0, 0, 0, 1, 0};
        vecs[4] = '{60,   1, 0, 20, 1, 60,   1, 0, 0, 0, 1};
        vecs[5] = '{1500, 1, 0, -1, 2, 1500, 1, 0, 0, 0, 0};
        vecs[6] = '{45,   1, 0, -1, 1, 45,   1, 1, 0, 0, 0};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset outputs",
              {dst_mac, src_mac, ethertype, hdr_valid, m_data, m_valid, m_last,
               frame_done, err_crc, err_short, err_long, err_line}, 128'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Broken preamble, then a good frame after a single idle cycle
        d0 = done_cnt;
        tx_q.delete();
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h12);
        send(3, -1, 1);
        check("badpre done", done_cnt - d0, 0);
        check("badpre hdr",  hdr_seen, 0);
        apply(vecs[0], "after_badpre");

        // Frame truncated inside the header
        d0 = done_cnt;
        build(46, 0, 0);
        c = crc_range(8, 15);
        send(16, -1, 2);
        check("runt_hdr done",  done_cnt - d0, 1);
        check("runt_hdr hdr",   s_hdr, 0);
        check("runt_hdr out",   s_out + s_last, 0);
        check("runt_hdr flags", s_flags, {1'b1, c != 32'hDEBB20E3, 1'b0, 1'b0});

        // Only three bytes after the header
        d0 = done_cnt;
        build(46, 0, 0);
        c = crc_range(8, 24);
        send(25, -1, 2);
        check("runt_pay done",  done_cnt - d0, 1);
        check("runt_pay hdr",   s_hdr, 1);
        check("runt_pay out",   s_out + s_last, 0);
        check("runt_pay flags", s_flags, {1'b1, c != 32'hDEBB20E3, 1'b0, 1'b0});

        // Reset pulse mid-payload, released while rx_valid is still high
        d0 = done_cnt;
        build(46, 0, 0);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == 40) rst_n = 1'b0;
            if (i == 41)
                check("midreset outputs",
                      {dst_mac, src_mac, ethertype, hdr_valid, m_data, m_valid, m_last,
                       frame_done, err_crc, err_short, err_long, err_line}, 128'h0);
            if (i == 42) rst_n = 1'b1;
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
            rx_err   = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("midreset done", done_cnt - d0, 0);
        check("midreset out",  out_cnt + last_cnt + hdr_seen, 0);
        apply(vecs[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
